// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word request at a time to instruction memory
// and holds the returned instruction for the decoder. Branch redirects may discard it.
module fetch_unit #(
    parameter int AW = 8,
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_en,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [IW-1:0] imem_rdata,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [IW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    output logic [3:0]    opcode,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [AW-1:0] pc, pc_next;
    logic [IW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          load_ir;

    // Handshakes: a memory transfer completes in any cycle imem_req & imem_valid
    // (imem_valid is only honoured in REQ/DRAIN); a decoder transfer completes in
    // any cycle if_valid & if_ready, and if_instr/if_pc never change while unaccepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            ir_pc <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (load_ir) begin
                ir    <= imem_rdata;
                ir_pc <= pc;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        load_ir    = 1'b0;
        if (redirect) begin
            pc_next = redirect_pc;
            case (state)
                S_IDLE:  state_next = S_IDLE;
                S_REQ:   state_next = imem_valid ? S_REQ : S_DRAIN;
                S_HOLD:  state_next = fetch_en ? S_REQ : S_IDLE;
                // A response arriving with the redirect still retires the stale request,
                // otherwise DRAIN would wait for a strobe that never comes.
                S_DRAIN: state_next = imem_valid ? (fetch_en ? S_REQ : S_IDLE) : S_DRAIN;
            endcase
        end else begin
            case (state)
                S_IDLE: if (fetch_en) state_next = S_REQ;
                S_REQ: begin
                    if (imem_valid) begin
                        load_ir    = 1'b1;
                        pc_next    = pc + AW'(1);
                        state_next = S_HOLD;
                    end
                end
                S_HOLD:  if (if_ready) state_next = fetch_en ? S_REQ : S_IDLE;
                S_DRAIN: if (imem_valid) state_next = fetch_en ? S_REQ : S_IDLE;
            endcase
        end
    end

    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;
    assign if_valid  = (state == S_HOLD);
    assign if_instr  = ir;
    assign if_pc     = ir_pc;
    assign opcode    = ir[IW-1 -: 4];
    assign dbg_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a monitor checks every decoder handshake against
// an expected queue of {pc, instr}; the stimulus process checks control outputs.
module tb_fetch_unit;
    localparam int AW = 8;
    localparam int IW = 16;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic          clk = 1'b0;
    logic          reset, fetch_en, imem_req, imem_valid, if_valid, if_ready, redirect;
    logic [AW-1:0] imem_addr, if_pc, redirect_pc;
    logic [IW-1:0] imem_rdata, if_instr;
    logic [3:0]    opcode;
    logic [1:0]    dbg_state;

    logic [AW+IW-1:0] exp_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    fetch_unit #(.AW(AW), .IW(IW)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .opcode(opcode),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic respond(input logic [IW-1:0] data, input logic accepted);
        imem_valid = 1'b1;
        imem_rdata = data;
        if (accepted) exp_q.push_back({imem_addr, data});
        tick();
        imem_valid = 1'b0;
    endtask

    // scoreboard monitor: every decoder handshake must match the queue head
    always @(negedge clk) begin
        if (!reset && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL handshake_unexpected: got %0h expected none", {if_pc, if_instr});
            end else begin
                check("handshake_pc_instr", 32'({if_pc, if_instr}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; fetch_en = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        if_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();
        reset = 1'b0;
        check("reset_if_valid", 32'(if_valid), 0);
        check("reset_imem_req", 32'(imem_req), 0);
        check("reset_imem_addr", 32'(imem_addr), 0);
        check("reset_opcode", 32'(opcode), 0);
        check("reset_if_pc", 32'(if_pc), 0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

        // first fetch at address 0, response one cycle after the request
        fetch_en = 1'b1;
        tick();
        check("req0_imem_req", 32'(imem_req), 1);
        check("req0_imem_addr", 32'(imem_addr), 0);
        tick();
        respond(16'h1234, 1'b1);
        check("hold0_if_valid", 32'(if_valid), 1);
        check("hold0_if_instr", 32'(if_instr), 32'h1234);
        check("hold0_opcode", 32'(opcode), 1);
        check("hold0_if_pc", 32'(if_pc), 0);
        check("hold0_next_addr", 32'(imem_addr), 1);

        // decoder stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_if_instr", 32'(if_instr), 32'h1234);
            check("stall_if_pc", 32'(if_pc), 0);
            check("stall_imem_req", 32'(imem_req), 0);
        end
        if_ready = 1'b1;
        tick();
        check("after_accept_req", 32'(imem_req), 1);
        check("after_accept_addr", 32'(imem_addr), 1);

        // redirect while request outstanding, response three cycles later is dropped
        redirect = 1'b1; redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        check("drain_state", 32'(dbg_state), 32'(ST_DRAIN));
        check("drain_imem_req", 32'(imem_req), 0);
        tick(); tick();
        respond(16'hBEEF, 1'b0);
        check("post_drain_req", 32'(imem_req), 1);
        check("post_drain_addr", 32'(imem_addr), 32'h40);
        check("post_drain_if_valid", 32'(if_valid), 0);
        respond(16'h5678, 1'b1);
        check("hold40_if_pc", 32'(if_pc), 32'h40);
        tick();
        check("req41_addr", 32'(imem_addr), 32'h41);

        // redirect coinciding with the response
        redirect = 1'b1; redirect_pc = 8'h10;
        respond(16'hDEAD, 1'b0);
        redirect = 1'b0;
        check("redir_same_req", 32'(imem_req), 1);
        check("redir_same_addr", 32'(imem_addr), 32'h10);
        check("redir_same_if_valid", 32'(if_valid), 0);

        // fetch at 0xFF wraps pc to 0
        redirect = 1'b1; redirect_pc = 8'hFF;
        respond(16'h0000, 1'b0);
        redirect = 1'b0;
        check("wrap_req_addr", 32'(imem_addr), 32'hFF);
        respond(16'hA0FF, 1'b1);
        check("wrap_opcode", 32'(opcode), 32'hA);
        check("wrap_if_pc", 32'(if_pc), 32'hFF);
        tick();
        check("wrap_next_req", 32'(imem_req), 1);
        check("wrap_next_addr", 32'(imem_addr), 0);

        // reset while holding an instruction, with redirect and fetch_en also high
        if_ready = 1'b0;
        respond(16'h7001, 1'b0);
        check("pre_reset_if_valid", 32'(if_valid), 1);
        check("pre_reset_if_instr", 32'(if_instr), 32'h7001);
        reset = 1'b1; redirect = 1'b1; redirect_pc = 8'h55;
        tick();
        reset = 1'b0; redirect = 1'b0; fetch_en = 1'b0;
        check("hold_reset_if_valid", 32'(if_valid), 0);
        check("hold_reset_addr", 32'(imem_addr), 0);
        check("hold_reset_state", 32'(dbg_state), 32'(ST_IDLE));
        check("hold_reset_if_instr", 32'(if_instr), 0);

        // stray response in IDLE is ignored
        respond(16'h9999, 1'b0);
        check("stray_state", 32'(dbg_state), 32'(ST_IDLE));
        check("stray_if_valid", 32'(if_valid), 0);

        // fetch_en drop mid-request completes that fetch but blocks the next one
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        check("fe_drop_req_held", 32'(imem_req), 1);
        if_ready = 1'b1;
        respond(16'h3003, 1'b1);
        check("fe_drop_if_instr", 32'(if_instr), 32'h3003);
        tick();
        check("fe_drop_state", 32'(dbg_state), 32'(ST_IDLE));
        check("fe_drop_req", 32'(imem_req), 0);
        check("fe_drop_addr", 32'(imem_addr), 1);

        tick();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
